// File: rtl/ddr3_sdram_s0_seq_debug_cmd_master_if.sv
// Host command port plus Avalon-MM master bus for the debug command master.
// master = command master side, slave = host/Avalon side.
interface ddr3_sdram_s0_seq_debug_cmd_master_if #(
  parameter int ADDR_W     = 20,
  parameter int MAX_PARAMS = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [31:0]             cmd_code;
  logic [3:0]              cmd_nparams;
  logic [32*MAX_PARAMS-1:0] cmd_params;

  logic                    rsp_valid;
  logic [31:0]             rsp_status;
  logic                    rsp_timeout;
  logic                    rsp_reject;

  logic [ADDR_W-1:0]       avm_address;
  logic                    avm_read;
  logic                    avm_write;
  logic [31:0]             avm_writedata;
  logic [31:0]             avm_readdata;
  logic                    avm_readdatavalid;
  logic                    avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_code, cmd_nparams, cmd_params,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_status, rsp_timeout, rsp_reject,
    output avm_address, avm_read, avm_write, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_code, cmd_nparams, cmd_params,
    output avm_readdata, avm_readdatavalid, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_status, rsp_timeout, rsp_reject,
    input  avm_address, avm_read, avm_write, avm_writedata
  );
endinterface

// File: rtl/ddr3_sdram_s0_seq_debug_cmd_master.sv
// Issues one debug command into the sequencer mailbox: params, command,
// poll REQ_CMD until cleared, then read CMD_STATUS back to the host.
module ddr3_sdram_s0_seq_debug_cmd_master #(
  parameter int          ADDR_W     = 20,
  parameter logic [31:0] DBG_BASE   = 32'h000151e0,
  parameter int          MAX_PARAMS = 4,
  parameter int          POLL_GAP   = 16,
  parameter int          POLL_LIMIT = 1024
) (
  input logic clk,
  input logic reset,
  ddr3_sdram_s0_seq_debug_cmd_master_if.master bus
);

  localparam int IDX_W  = $clog2(MAX_PARAMS + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int PCNT_W = $clog2(POLL_LIMIT + 1);

  localparam logic [3:0] MAXP = 4'(MAX_PARAMS);

  localparam logic [ADDR_W-1:0] A_REQ  = ADDR_W'(DBG_BASE + 32'h8);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(DBG_BASE + 32'hC);
  localparam logic [ADDR_W-1:0] A_PAR  = ADDR_W'(DBG_BASE + 32'h10);

  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [PCNT_W-1:0] PLIM     = PCNT_W'(POLL_LIMIT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PARAM,
    S_WR_CMD,
    S_GAP,
    S_POLL_RD,
    S_POLL_WAIT,
    S_ST_RD,
    S_ST_WAIT,
    S_RESP
  } state_e;

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [3:0]                   np_q, np_d;
  logic [31:0]                  code_q, code_d;
  logic [MAX_PARAMS-1:0][31:0]  par_q, par_d;
  logic [GAP_W-1:0]             gap_q, gap_d;
  logic [PCNT_W-1:0]            poll_q, poll_d;
  logic [31:0]                  stat_q, stat_d;
  logic                         to_q, to_d;
  logic                         rej_q, rej_d;

  logic [31:0]       par_sel;
  logic              ready_o;
  logic              rspv_o;
  logic              rd_o;
  logic              wr_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       wdata_o;

  // Select the parameter word for the current write index.
  always_comb begin
    par_sel = '0;
    for (int i = 0; i < MAX_PARAMS; i++) begin
      if (idx_q == IDX_W'(i)) par_sel = par_q[i];
    end
  end

  // Next-state and bus strobes; strobes are decoded from state so they
  // hold steady under waitrequest and drop when the state advances.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    np_d    = np_q;
    code_d  = code_q;
    par_d   = par_q;
    gap_d   = gap_q;
    poll_d  = poll_q;
    stat_d  = stat_q;
    to_d    = to_q;
    rej_d   = rej_q;
    ready_o = 1'b0;
    rspv_o  = 1'b0;
    rd_o    = 1'b0;
    wr_o    = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    unique case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (bus.cmd_valid) begin
          code_d = bus.cmd_code;
          for (int i = 0; i < MAX_PARAMS; i++) begin
            par_d[i] = bus.cmd_params[32*i +: 32];
          end
          np_d  = (bus.cmd_nparams > MAXP) ? MAXP : bus.cmd_nparams;
          idx_d = '0;
          if (bus.cmd_code == 32'h0) begin
            stat_d  = '0;
            to_d    = 1'b0;
            rej_d   = 1'b1;
            state_d = S_RESP;
          end else if (np_d == 4'd0) begin
            state_d = S_WR_CMD;
          end else begin
            state_d = S_WR_PARAM;
          end
        end
      end
      S_WR_PARAM: begin
        wr_o    = 1'b1;
        addr_o  = A_PAR + ADDR_W'({idx_q, 2'b00});
        wdata_o = par_sel;
        if (!bus.avm_waitrequest) begin
          idx_d = idx_q + IDX_W'(1);
          if (4'(idx_d) == np_q) state_d = S_WR_CMD;
        end
      end
      S_WR_CMD: begin
        wr_o    = 1'b1;
        addr_o  = A_REQ;
        wdata_o = code_q;
        if (!bus.avm_waitrequest) begin
          gap_d   = '0;
          poll_d  = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_POLL_RD;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_POLL_RD: begin
        rd_o   = 1'b1;
        addr_o = A_REQ;
        if (!bus.avm_waitrequest) state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (bus.avm_readdatavalid) begin
          if (bus.avm_readdata == 32'h0) begin
            state_d = S_ST_RD;
          end else begin
            poll_d = poll_q + PCNT_W'(1);
            gap_d  = '0;
            if (poll_d == PLIM) begin
              stat_d  = '0;
              to_d    = 1'b1;
              rej_d   = 1'b0;
              state_d = S_RESP;
            end else begin
              state_d = S_GAP;
            end
          end
        end
      end
      S_ST_RD: begin
        rd_o   = 1'b1;
        addr_o = A_STAT;
        if (!bus.avm_waitrequest) state_d = S_ST_WAIT;
      end
      S_ST_WAIT: begin
        if (bus.avm_readdatavalid) begin
          stat_d  = bus.avm_readdata;
          to_d    = 1'b0;
          rej_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rspv_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset returns to IDLE at once, which
  // also discards any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      np_q    <= '0;
      code_q  <= '0;
      par_q   <= '0;
      gap_q   <= '0;
      poll_q  <= '0;
      stat_q  <= '0;
      to_q    <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      np_q    <= np_d;
      code_q  <= code_d;
      par_q   <= par_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      stat_q  <= stat_d;
      to_q    <= to_d;
      rej_q   <= rej_d;
    end
  end

  assign bus.cmd_ready     = ready_o;
  assign bus.rsp_valid     = rspv_o;
  assign bus.rsp_status    = stat_q;
  assign bus.rsp_timeout   = to_q;
  assign bus.rsp_reject    = rej_q;
  assign bus.avm_address   = addr_o;
  assign bus.avm_read      = rd_o;
  assign bus.avm_write     = wr_o;
  assign bus.avm_writedata = wdata_o;

endmodule

// File: tb/tb_ddr3_sdram_s0_seq_debug_cmd_master.sv
// Directed bench for the debug command master with a small Avalon
// mailbox slave (configurable stalls, poll count, status value).
module tb_ddr3_sdram_s0_seq_debug_cmd_master;

  localparam logic [19:0] REQ  = 20'h151e8;
  localparam logic [19:0] STAT = 20'h151ec;
  localparam logic [19:0] PAR  = 20'h151f0;

  logic clk;
  logic reset;

  ddr3_sdram_s0_seq_debug_cmd_master_if #(.ADDR_W(20), .MAX_PARAMS(4)) bus ();

  ddr3_sdram_s0_seq_debug_cmd_master #(
    .ADDR_W(20),
    .DBG_BASE(32'h000151e0),
    .MAX_PARAMS(4),
    .POLL_GAP(16),
    .POLL_LIMIT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
    int          cyc;
  } xact_t;

  typedef struct {
    logic [31:0]  code;
    logic [3:0]   np;
    logic [127:0] par;
    int           polls;
    logic [31:0]  stat;
    int           stall;
    logic [31:0]  e_status;
    logic         e_to;
    logic         e_rej;
    int           e_wr;
    int           e_rd;
    int           e_lat;
  } vec_t;

  xact_t wlog[$];
  xact_t rlog[$];
  vec_t  vt[7];

  int cfg_polls = 0;
  int cfg_stall = 0;
  logic [31:0] cfg_stat = '0;
  logic stray = 1'b0;

  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int rsp_cnt = 0;
  logic [31:0] rs_stat = '0;
  logic rs_to = 1'b0;
  logic rs_rej = 1'b0;
  int stall_cnt = 0;
  int req_reads = 0;
  int stab_err = 0;
  int proto_err = 0;
  logic stalled_q = 1'b0;
  logic sv_rd = 1'b0;
  logic sv_wr = 1'b0;
  logic [19:0] sv_addr = '0;
  logic [31:0] sv_data = '0;
  logic rdv_q = 1'b0;
  logic [31:0] rdata_q = '0;

  int n_chk = 0;
  int n_pass = 0;

  assign bus.avm_waitrequest =
    (bus.avm_read || bus.avm_write) && (stall_cnt < cfg_stall);
  assign bus.avm_readdatavalid = rdv_q | stray;
  assign bus.avm_readdata = stray ? 32'h0 : rdata_q;

  // Mailbox slave model plus response/protocol monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cmd_valid && bus.cmd_ready) acc_cyc <= cyc;
    if (bus.rsp_valid) begin
      rsp_cyc <= cyc;
      rsp_cnt <= rsp_cnt + 1;
      rs_stat <= bus.rsp_status;
      rs_to   <= bus.rsp_timeout;
      rs_rej  <= bus.rsp_reject;
    end
    if (bus.avm_read && bus.avm_write) proto_err <= proto_err + 1;
    if (stalled_q && (bus.avm_read !== sv_rd || bus.avm_write !== sv_wr ||
        bus.avm_address !== sv_addr || bus.avm_writedata !== sv_data))
      stab_err <= stab_err + 1;
    stalled_q <= (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
    sv_rd   <= bus.avm_read;
    sv_wr   <= bus.avm_write;
    sv_addr <= bus.avm_address;
    sv_data <= bus.avm_writedata;
    rdv_q <= 1'b0;
    if ((bus.avm_read || bus.avm_write) && bus.avm_waitrequest)
      stall_cnt <= stall_cnt + 1;
    if (bus.avm_write && !bus.avm_waitrequest) begin
      stall_cnt <= 0;
      wlog.push_back('{bus.avm_address, bus.avm_writedata, cyc});
      if (bus.avm_address == REQ) req_reads <= 0;
    end
    if (bus.avm_read && !bus.avm_waitrequest) begin
      stall_cnt <= 0;
      if (rdv_q) proto_err <= proto_err + 1;
      rlog.push_back('{bus.avm_address, 32'h0, cyc});
      rdv_q <= 1'b1;
      if (bus.avm_address == REQ) begin
        rdata_q   <= (req_reads < cfg_polls) ? 32'h5 : 32'h0;
        req_reads <= req_reads + 1;
      end else if (bus.avm_address == STAT) begin
        rdata_q <= cfg_stat;
      end else begin
        rdata_q <= 32'hdead;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic issue(input logic [31:0] code, input logic [3:0] np,
                       input logic [127:0] par);
    int k;
    bus.cmd_valid   = 1'b1;
    bus.cmd_code    = code;
    bus.cmd_nparams = np;
    bus.cmd_params  = par;
    k = 0;
    while (!bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("cmd accepted", 32'(bus.cmd_ready), 32'h1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int v);
    int wb, rb, rc, k, nw, nr, nexp;
    logic [19:0] ea;
    cfg_polls = vt[v].polls;
    cfg_stat  = vt[v].stat;
    cfg_stall = vt[v].stall;
    wb = wlog.size();
    rb = rlog.size();
    rc = rsp_cnt;
    issue(vt[v].code, vt[v].np, vt[v].par);
    k = 0;
    while (rsp_cnt == rc && k < 1000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    nw = wlog.size() - wb;
    nr = rlog.size() - rb;
    chk($sformatf("v%0d rsp pulses", v), 32'(rsp_cnt - rc), 32'h1);
    chk($sformatf("v%0d status", v), rs_stat, vt[v].e_status);
    chk($sformatf("v%0d timeout", v), 32'(rs_to), 32'(vt[v].e_to));
    chk($sformatf("v%0d reject", v), 32'(rs_rej), 32'(vt[v].e_rej));
    chk($sformatf("v%0d latency", v), 32'(rsp_cyc - acc_cyc),
        32'(vt[v].e_lat));
    chk($sformatf("v%0d n writes", v), 32'(nw), 32'(vt[v].e_wr));
    chk($sformatf("v%0d n reads", v), 32'(nr), 32'(vt[v].e_rd));
    nexp = (vt[v].np > 4'd4) ? 4 : int'(vt[v].np);
    for (int j = 0; j < nw && j < vt[v].e_wr; j++) begin
      if (j < nexp) begin
        chk($sformatf("v%0d w%0d addr", v, j), 32'(wlog[wb+j].addr),
            32'(PAR + 20'(4 * j)));
        chk($sformatf("v%0d w%0d data", v, j), wlog[wb+j].data,
            vt[v].par[32*j +: 32]);
      end else begin
        chk($sformatf("v%0d cmd addr", v), 32'(wlog[wb+j].addr), 32'(REQ));
        chk($sformatf("v%0d cmd data", v), wlog[wb+j].data, vt[v].code);
      end
    end
    for (int j = 0; j < nr && j < vt[v].e_rd; j++) begin
      ea = (j == vt[v].e_rd - 1 && !vt[v].e_to) ? STAT : REQ;
      chk($sformatf("v%0d r%0d addr", v, j), 32'(rlog[rb+j].addr), 32'(ea));
      if (j > 0 && vt[v].stall == 0 && ea == REQ)
        chk($sformatf("v%0d r%0d spacing", v, j),
            32'(rlog[rb+j].cyc - rlog[rb+j-1].cyc), 32'd18);
    end
    chk($sformatf("v%0d stable under stall", v), 32'(stab_err), 32'h0);
    chk($sformatf("v%0d protocol", v), 32'(proto_err), 32'h0);
  endtask

  initial begin
    int rb, wb, rc, k;
    vt[0] = '{32'h5, 4'd2, {64'h0, 32'h22, 32'h11}, 0, 32'ha5, 0,
              32'ha5, 1'b0, 1'b0, 3, 2, 24};
    vt[1] = '{32'h5, 4'd2, {64'h0, 32'h22, 32'h11}, 0, 32'ha5, 3,
              32'ha5, 1'b0, 1'b0, 3, 2, 39};
    vt[2] = '{32'h7, 4'd0, 128'h0, 3, 32'h3c, 0,
              32'h3c, 1'b0, 1'b0, 1, 5, 76};
    vt[3] = '{32'h9, 4'd1, {96'h0, 32'h33}, 99, 32'h77, 0,
              32'h0, 1'b1, 1'b0, 2, 8, 147};
    vt[4] = '{32'h0, 4'd3, {96'h0, 32'h44}, 0, 32'h55, 0,
              32'h0, 1'b0, 1'b1, 0, 0, 1};
    vt[5] = '{32'h12, 4'd7, {32'h4, 32'h3, 32'h2, 32'h1}, 0, 32'h1, 0,
              32'h1, 1'b0, 1'b0, 5, 2, 26};
    vt[6] = '{32'h3, 4'd0, 128'h0, 0, 32'hbeef, 0,
              32'hbeef, 1'b0, 1'b0, 1, 2, 22};

    reset = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_code    = '0;
    bus.cmd_nparams = '0;
    bus.cmd_params  = '0;
    repeat (3) @(negedge clk);
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst avm_read", 32'(bus.avm_read), 32'h0);
    chk("rst avm_write", 32'(bus.avm_write), 32'h0);
    chk("rst avm_address", 32'(bus.avm_address), 32'h0);
    chk("rst rsp_status", bus.rsp_status, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) run_vec(v);

    // Reset during POLL_WAIT followed by a stray readdatavalid.
    cfg_polls = 99;
    cfg_stall = 0;
    rb = rlog.size();
    rc = rsp_cnt;
    issue(32'h4, 4'd0, 128'h0);
    k = 0;
    while (rlog.size() == rb && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t6 first poll issued", 32'(rlog.size() - rb), 32'h1);
    wb = wlog.size();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6 cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("t6 avm_read", 32'(bus.avm_read), 32'h0);
    chk("t6 avm_write", 32'(bus.avm_write), 32'h0);
    chk("t6 rsp_status", bus.rsp_status, 32'h0);
    chk("t6 rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
    chk("t6 no rsp", 32'(rsp_cnt - rc), 32'h0);
    chk("t6 no extra reads", 32'(rlog.size() - rb), 32'h1);
    chk("t6 no writes", 32'(wlog.size() - wb), 32'h0);
    run_vec(0);
    repeat (5) @(negedge clk);
    chk("status hold", bus.rsp_status, 32'ha5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
